// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision float library.
// Holds IEEE-754 field widths, special encodings and the operand class.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [31:0] POS_INF = 32'h7f800000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  // Denormals are classed as ZERO: they are flushed on entry.
  function automatic fp_class_t fp_classify(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    if (e == '0)
      return ZERO;
    if (e == EXP_W'(EXP_MAX))
      return (m == '0) ? INF : NAN;
    return NORM;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalize, round and pack the squared significand; select specials.
// Ports: prod/e2/cls in; data plus ovf/unf/nan flags out.
// FP_SQUARE_RNE_EN selects round-to-nearest-even, else truncation.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic [47:0]       prod,
  input  logic signed [9:0] e2,
  input  fp_class_t         cls,
  output logic [31:0]       data,
  output logic              ovf,
  output logic              unf,
  output logic              nan
);

  localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

  logic signed [9:0] e_n;
  logic signed [9:0] e_f;
  logic [MAN_W-1:0]  mant;
  logic [MAN_W-1:0]  mant_f;

`ifdef FP_SQUARE_RNE_EN
  logic              grd;
  logic              stk;
  logic [MAN_W:0]    rnd;

  always_comb begin
    e_n  = e2;
    mant = prod[45:23];
    grd  = prod[22];
    stk  = |prod[21:0];
    if (prod[47]) begin
      e_n  = e2 + 10'sd1;
      mant = prod[46:24];
      grd  = prod[23];
      stk  = |prod[22:0];
    end
    rnd    = {1'b0, mant}
           + {{MAN_W{1'b0}}, grd & (stk | mant[0])};
    // A carry means 1.11..1 rounded up to 2.0: the
    // fraction is already zero, only bump the exponent.
    e_f    = e_n + $signed({9'd0, rnd[MAN_W]});
    mant_f = rnd[MAN_W-1:0];
  end
`else
  logic unused_lsbs;

  assign unused_lsbs = ^prod[22:0];

  always_comb begin
    e_n  = e2;
    mant = prod[45:23];
    if (prod[47]) begin
      e_n  = e2 + 10'sd1;
      mant = prod[46:24];
    end
    e_f    = e_n;
    mant_f = mant;
  end
`endif

  always_comb begin
    data = '0;
    ovf  = 1'b0;
    unf  = 1'b0;
    nan  = 1'b0;
    unique case (cls)
      NAN: begin
        data = QNAN;
        nan  = 1'b1;
      end
      INF:  data = POS_INF;
      ZERO: data = '0;
      NORM: begin
        if (e_f >= EMAX) begin
          data = POS_INF;
          ovf  = 1'b1;
        end else if (e_f <= 10'sd0) begin
          unf  = 1'b1;
        end else begin
          data = {1'b0, e_f[7:0], mant_f};
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_square_pipe.sv
// Pipelined single-precision squarer, out = in*in, latency 3.
// Ports: clk, rst; in_data/in_valid/in_ready; out_data/out_valid/
// out_ready; out_ovf/out_unf/out_nan. Macro: FP_SQUARE_RNE_EN.
module fp_square_pipe
  import fp_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_nan
);

  if (LATENCY != 3) begin : g_lat_err
    $error("fp_square_pipe: LATENCY must be 3");
  end

  localparam logic signed [9:0] BIAS10 = 10'(BIAS);

  fp32_t in_f;
  logic  unused_sign;
  logic  adv;

  logic                v0_d, v0_q;
  logic [EXP_W-1:0]    exp0_d, exp0_q;
  logic [MAN_W-1:0]    man0_d, man0_q;

  logic                v1_d, v1_q;
  fp_class_t           cls1_d, cls1_q;
  logic [EXP_W-1:0]    exp1_d, exp1_q;
  logic [MAN_W:0]      sig1_d, sig1_q;

  logic                v2_d, v2_q;
  fp_class_t           cls2_d, cls2_q;
  logic [47:0]         prod2_d, prod2_q;
  logic signed [9:0]   e2_d, e2_q;

  logic                ov_d, ov_q;
  logic [31:0]         od_d, od_q;
  logic                ovf_d, ovf_q;
  logic                unf_d, unf_q;
  logic                nan_d, nan_q;

  logic [31:0]         rp_data;
  logic                rp_ovf, rp_unf, rp_nan;

  // Sign never matters for a square.
  assign in_f        = in_data;
  assign unused_sign = in_f.sign;

  // One global enable: the whole pipe freezes on backpressure.
  assign adv       = ~ov_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign out_nan   = nan_q;

  fp_round_pack u_round_pack (
    .prod (prod2_q),
    .e2   (e2_q),
    .cls  (cls2_q),
    .data (rp_data),
    .ovf  (rp_ovf),
    .unf  (rp_unf),
    .nan  (rp_nan)
  );

  always_comb begin
    v0_d    = v0_q;
    exp0_d  = exp0_q;
    man0_d  = man0_q;
    v1_d    = v1_q;
    cls1_d  = cls1_q;
    exp1_d  = exp1_q;
    sig1_d  = sig1_q;
    v2_d    = v2_q;
    cls2_d  = cls2_q;
    prod2_d = prod2_q;
    e2_d    = e2_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    nan_d   = nan_q;
    if (adv) begin
      v0_d    = in_valid;
      exp0_d  = in_f.exp;
      man0_d  = in_f.man;

      v1_d    = v0_q;
      cls1_d  = fp_classify(exp0_q, man0_q);
      exp1_d  = exp0_q;
      sig1_d  = {1'b1, man0_q};

      v2_d    = v1_q;
      cls2_d  = cls1_q;
      prod2_d = 48'(sig1_q) * 48'(sig1_q);
      e2_d    = $signed({1'b0, exp1_q, 1'b0}) - BIAS10;

      ov_d    = v2_q;
      od_d    = rp_data;
      ovf_d   = rp_ovf;
      unf_d   = rp_unf;
      nan_d   = rp_nan;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      exp0_q  <= '0;
      man0_q  <= '0;
      v1_q    <= 1'b0;
      cls1_q  <= ZERO;
      exp1_q  <= '0;
      sig1_q  <= '0;
      v2_q    <= 1'b0;
      cls2_q  <= ZERO;
      prod2_q <= '0;
      e2_q    <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      v0_q    <= v0_d;
      exp0_q  <= exp0_d;
      man0_q  <= man0_d;
      v1_q    <= v1_d;
      cls1_q  <= cls1_d;
      exp1_q  <= exp1_d;
      sig1_q  <= sig1_d;
      v2_q    <= v2_d;
      cls2_q  <= cls2_d;
      prod2_q <= prod2_d;
      e2_q    <= e2_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      nan_q   <= nan_d;
    end
  end

endmodule

// File: tb/tb_fp_square_pipe.sv
// Self-checking bench for fp_square_pipe.
// Reference squares in double precision and rounds to single.
module tb_fp_square_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_ovf;
  logic        out_unf;
  logic        out_nan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_square_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_nan   (out_nan)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Returns {ovf, unf, nan, data}.
  function automatic logic [34:0] model(input logic [31:0] a);
    logic [7:0]  e;
    logic [22:0] m;
    real         x;
    real         y;
    logic [63:0] b;
    int          fe;
    logic [23:0] fm;
    e = a[30:23];
    m = a[22:0];
    if (e == 8'd0)
      return 35'd0;
    if (e == 8'hff)
      return (m != 0) ? {3'b001, 32'h7fc00000}
                      : {3'b000, 32'h7f800000};
    x  = $bitstoreal({1'b0, 11'(int'(e) + 896), m, 29'd0});
    y  = x * x;
    b  = $realtobits(y);
    fe = int'(b[62:52]) - 896;
    fm = {1'b0, b[51:29]};
`ifdef FP_SQUARE_RNE_EN
    if (b[28] && ((|b[27:0]) || b[29]))
      fm = fm + 24'd1;
    if (fm[23])
      fe = fe + 1;
`endif
    if (fe >= 255)
      return {3'b100, 32'h7f800000};
    if (fe <= 0)
      return {3'b010, 32'h0};
    return {3'b000, 1'b0, 8'(fe), fm[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int          k;
    k = $urandom_range(0, 9);
    m = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin
        e = 8'hff;
        if ($urandom_range(0, 1) == 0)
          m = '0;
      end
      2: e = 8'($urandom_range(60, 66));
      3: e = 8'($urandom_range(188, 194));
      4: begin
        e = 8'($urandom_range(1, 254));
        m = '1;
      end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    checks++;
    if ({out_ovf, out_unf, out_nan} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000",
               {out_ovf, out_unf, out_nan});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] vin [11] = '{
      32'h3fc00000, 32'h40400000, 32'hc0000000,
      32'h60000000, 32'h1f800000, 32'h00000001,
      32'h7f800001, 32'hff800000, 32'h3f800801,
      32'h3f800800, 32'h3f800000};
    logic [31:0] vout [11] = '{
      32'h40100000, 32'h41100000, 32'h40800000,
      32'h7f800000, 32'h00000000, 32'h00000000,
      32'h7fc00000, 32'h7f800000, 32'h3f801002,
      32'h3f801000, 32'h3f800000};
    logic [2:0] vflg [11] = '{
      3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b000,
      3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    int lat;
`ifdef FP_SQUARE_RNE_EN
    vout[8] = 32'h3f801003;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_data  = vin[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 8) begin
        tick();
        lat++;
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL dir_latency %h: got %0d want 3",
                 vin[i], lat);
      end
      checks++;
      if (out_data !== vout[i]) begin
        errors++;
        $display("FAIL dir_data %h: got %h want %h",
                 vin[i], out_data, vout[i]);
      end
      checks++;
      if ({out_ovf, out_unf, out_nan} !== vflg[i]) begin
        errors++;
        $display("FAIL dir_flags %h: got %b want %b",
                 vin[i], {out_ovf, out_unf, out_nan}, vflg[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops [8];
    logic [34:0] exp_q [$];
    logic [34:0] e;
    logic [31:0] held = '0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < 8; i++)
      ops[i] = {1'($urandom), 8'($urandom_range(100, 150)),
                23'($urandom)};
    while (got < 8 && cyc < 60) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? ops[sent] : 32'h0;
      out_ready = !(cyc >= 5 && cyc < 9);
      @(negedge clk);
      if (cyc >= 5 && cyc < 9) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready cyc %0d: got %b want 0",
                   cyc, in_ready);
        end
        if (cyc == 5)
          held = out_data;
        else begin
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("FAIL b2b_stable cyc %0d: got %h want %h",
                     cyc, out_data, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_unf, out_nan, out_data} !== e) begin
            errors++;
            $display("FAIL b2b_data #%0d: got %h want %h", got,
                     {out_ovf, out_unf, out_nan, out_data}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        sent++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (got !== 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 8", got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ops [$];
    logic [34:0] exp_q [$];
    logic [34:0] e;
    int n = 300;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < n; i++)
      ops.push_back(rand_op());
    while (got < n && cyc < 4000) begin
      in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      in_data   = (sent < n) ? ops[sent] : 32'h0;
      out_ready = (cyc > 3000) || ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_ovf, out_unf, out_nan, out_data} !== e) begin
            errors++;
            $display("FAIL rnd_data #%0d: got %h want %h", got,
                     {out_ovf, out_unf, out_nan, out_data}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        sent++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (got !== n) begin
      errors++;
      $display("FAIL rnd_count: got %0d want %0d", got, n);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data  = 32'h40000000 + 32'(i << 20);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_valid: got %b want 0", out_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid)
        stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL mid_reset_stale: got %0d want 0", stale);
    end
    in_data  = 32'h3f800000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL mid_reset_latency: got %0d want 3", lat);
    end
    checks++;
    if (out_data !== 32'h3f800000) begin
      errors++;
      $display("FAIL mid_reset_data: got %h want 3f800000",
               out_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
